// File: rtl/ttt_turn_controller.sv
// ttt_turn_controller
//   Sequencing controller for the tic-tac-toe datapath. Arbitrates moves from
//   two players, decodes row/column pairs to one-hot cells, rejects illegal
//   moves, commits legal ones into the board registers, detects win/draw and
//   alternates turns. Owns the board state.
//
// Optional feature macro: TTT_MOVE_TIMEOUT_EN
//   Defined   : per-turn counter; a turn with no committed move for
//               TIMEOUT_CYCLES cycles pulses `timeout` and passes the turn.
//   Undefined : no counter, `timeout` tied to 0, turns wait indefinitely.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start                 begin/restart a game (highest priority)
//   p1_valid/row/col      player 1 (X) move request, coordinates 1..3
//   p2_valid/row/col      player 2 (O) move request, coordinates 1..3
//   p1_ack, p2_ack        one-cycle pulse: move committed
//   reject                one-cycle pulse: current player's move illegal
//   timeout               one-cycle pulse: turn forfeited
//   board_x, board_o      occupancy, bit (row-1)*3+(col-1)
//   turn                  0 = X to move, 1 = O to move
//   busy                  game in progress (TURN/CHECK)
//   game_over             game finished
//   winner                00 none, 01 X, 10 O, 11 draw
// All outputs are registered.

module ttt_turn_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       p1_valid,
  input  logic [1:0] p1_row,
  input  logic [1:0] p1_col,
  input  logic       p2_valid,
  input  logic [1:0] p2_row,
  input  logic [1:0] p2_col,
  output logic       p1_ack,
  output logic       p2_ack,
  output logic       reject,
  output logic       timeout,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       turn,
  output logic       busy,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned CELLS = 9;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TURN  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Row/col pair to one-hot cell; zero when either coordinate is 0.
  function automatic logic [CELLS-1:0] cell_onehot(input logic [1:0] row,
                                                   input logic [1:0] col);
    logic [CELLS-1:0] oh;
    oh = '0;
    case ({row, col})
      4'b01_01: oh = 9'h001;
      4'b01_10: oh = 9'h002;
      4'b01_11: oh = 9'h004;
      4'b10_01: oh = 9'h008;
      4'b10_10: oh = 9'h010;
      4'b10_11: oh = 9'h020;
      4'b11_01: oh = 9'h040;
      4'b11_10: oh = 9'h080;
      4'b11_11: oh = 9'h100;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

  // Any of the 8 lines fully owned by one board.
  function automatic logic line_complete(input logic [CELLS-1:0] b);
    return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  state_t           state_q, state_d;
  logic [CELLS-1:0] board_x_d, board_o_d;
  logic             turn_d, busy_d, game_over_d;
  logic [1:0]       winner_d;
  logic             p1_ack_d, p2_ack_d, reject_d, timeout_d;

  // Current player's request, muxed by turn.
  logic             mv_valid;
  logic [1:0]       mv_row, mv_col;
  logic [CELLS-1:0] mv_oh, occupied, mover_board;
  logic             mv_legal;

  assign mv_valid    = turn ? p2_valid : p1_valid;
  assign mv_row      = turn ? p2_row   : p1_row;
  assign mv_col      = turn ? p2_col   : p1_col;
  assign mv_oh       = cell_onehot(mv_row, mv_col);
  assign occupied    = board_x | board_o;
  assign mv_legal    = (|mv_oh) && ((mv_oh & occupied) == '0);
  assign mover_board = turn ? board_o : board_x;

`ifdef TTT_MOVE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_expire;

  assign tmo_expire = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Per-turn cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      board_x   <= '0;
      board_o   <= '0;
      turn      <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
      p1_ack    <= 1'b0;
      p2_ack    <= 1'b0;
      reject    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_x   <= board_x_d;
      board_o   <= board_o_d;
      turn      <= turn_d;
      busy      <= busy_d;
      game_over <= game_over_d;
      winner    <= winner_d;
      p1_ack    <= p1_ack_d;
      p2_ack    <= p2_ack_d;
      reject    <= reject_d;
      timeout   <= timeout_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    board_x_d = board_x;
    board_o_d = board_o;
    turn_d    = turn;
    winner_d  = winner;
    p1_ack_d  = 1'b0;
    p2_ack_d  = 1'b0;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
`ifdef TTT_MOVE_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    if (start) begin
      // Restart wins over everything, including a move in the same cycle.
      state_d   = S_TURN;
      board_x_d = '0;
      board_o_d = '0;
      turn_d    = 1'b0;
      winner_d  = WIN_NONE;
`ifdef TTT_MOVE_TIMEOUT_EN
      tmo_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end

        S_TURN: begin
          if (mv_valid && mv_legal) begin
            if (turn) begin
              board_o_d = board_o | mv_oh;
              p2_ack_d  = 1'b1;
            end else begin
              board_x_d = board_x | mv_oh;
              p1_ack_d  = 1'b1;
            end
            state_d = S_CHECK;
          end else begin
            reject_d = mv_valid;
`ifdef TTT_MOVE_TIMEOUT_EN
            // Rejected attempts keep the clock running.
            if (tmo_expire) begin
              timeout_d = 1'b1;
              turn_d    = ~turn;
              tmo_cnt_d = '0;
            end else begin
              tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
`endif
          end
        end

        S_CHECK: begin
          if (line_complete(mover_board)) begin
            winner_d = turn ? WIN_O : WIN_X;
            state_d  = S_DONE;
          end else if (&occupied) begin
            winner_d = WIN_DRAW;
            state_d  = S_DONE;
          end else begin
            turn_d  = ~turn;
            state_d = S_TURN;
`ifdef TTT_MOVE_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end

        S_DONE: begin
          state_d = S_DONE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d      = (state_d == S_TURN) || (state_d == S_CHECK);
    game_over_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Directed self-checking bench for ttt_turn_controller.
module tb_ttt_turn_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       p1_valid, p2_valid;
  logic [1:0] p1_row, p1_col, p2_row, p2_col;
  logic       p1_ack, p2_ack, reject, timeout;
  logic [8:0] board_x, board_o;
  logic       turn, busy, game_over;
  logic [1:0] winner;

  int n_cmp = 0;
  int n_err = 0;

  ttt_turn_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .p1_valid (p1_valid),
    .p1_row   (p1_row),
    .p1_col   (p1_col),
    .p2_valid (p2_valid),
    .p2_row   (p2_row),
    .p2_col   (p2_col),
    .p1_ack   (p1_ack),
    .p2_ack   (p2_ack),
    .reject   (reject),
    .timeout  (timeout),
    .board_x  (board_x),
    .board_o  (board_o),
    .turn     (turn),
    .busy     (busy),
    .game_over(game_over),
    .winner   (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present a move for one edge; outputs of that edge are visible on return.
  task automatic drive_move(input logic pl, input logic [1:0] r, input logic [1:0] c);
    if (!pl) begin
      p1_valid = 1'b1; p1_row = r; p1_col = c;
    end else begin
      p2_valid = 1'b1; p2_row = r; p2_col = c;
    end
    step();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] obs;
    rst_n = 1'b0;
    step();
    step();
    obs = {board_x, board_o, turn, busy, game_over, winner, p1_ack, p2_ack, reject, timeout};
    n_cmp++;
    if (obs !== 27'd0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0", obs);
    end
    rst_n = 1'b1;
    step();
    do_start();
    n_cmp++;
    if ({busy, turn, board_x, board_o} !== {1'b1, 1'b0, 18'd0}) begin
      n_err++;
      $display("FAIL start_busy busy=%b turn=%b x=%h o=%h exp busy=1 turn=0 boards=0",
               busy, turn, board_x, board_o);
    end
  endtask

  task automatic test_x_wins();
    logic [1:0] rows [5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    logic [1:0] cols [5] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [1:0] exp_ack;
    do_start();
    for (int i = 0; i < 5; i++) begin
      drive_move(1'(i % 2), rows[i], cols[i]);
      exp_ack = (i % 2 == 0) ? 2'b10 : 2'b01;
      n_cmp++;
      if ({p1_ack, p2_ack} !== exp_ack || reject !== 1'b0) begin
        n_err++;
        $display("FAIL xwin_ack move=%0d got acks=%b rej=%b exp acks=%b rej=0",
                 i, {p1_ack, p2_ack}, reject, exp_ack);
      end
      step();
    end
    n_cmp++;
    if ({board_x, board_o, winner, game_over, busy} !== {9'h007, 9'h018, 2'b01, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL xwin_final x=%h o=%h win=%b go=%b busy=%b exp x=007 o=018 win=01 go=1 busy=0",
               board_x, board_o, winner, game_over, busy);
    end
    // Board frozen in DONE.
    p1_valid = 1'b1; p1_row = 2'd3; p1_col = 2'd3;
    p2_valid = 1'b1; p2_row = 2'd3; p2_col = 2'd1;
    step(); step();
    p1_valid = 1'b0; p2_valid = 1'b0;
    n_cmp++;
    if ({board_x, board_o, p1_ack, p2_ack, reject, game_over} !== {9'h007, 9'h018, 3'b000, 1'b1}) begin
      n_err++;
      $display("FAIL done_frozen x=%h o=%h acks=%b%b rej=%b go=%b exp x=007 o=018 no pulses go=1",
               board_x, board_o, p1_ack, p2_ack, reject, game_over);
    end
  endtask

  task automatic test_draw();
    logic [1:0] rows [9] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [1:0] cols [9] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3};
    int acks;
    acks = 0;
    do_start();
    for (int i = 0; i < 9; i++) begin
      drive_move(1'(i % 2), rows[i], cols[i]);
      if (p1_ack || p2_ack) acks++;
      step();
    end
    n_cmp++;
    if (acks !== 9) begin
      n_err++;
      $display("FAIL draw_acks got=%0d exp=9", acks);
    end
    n_cmp++;
    if ({board_x, board_o, winner, game_over} !== {9'h18D, 9'h072, 2'b11, 1'b1}) begin
      n_err++;
      $display("FAIL draw_final x=%h o=%h win=%b go=%b exp x=18d o=072 win=11 go=1",
               board_x, board_o, winner, game_over);
    end
  endtask

  task automatic test_illegal();
    do_start();
    drive_move(1'b0, 2'd2, 2'd2);
    n_cmp++;
    if (p1_ack !== 1'b1) begin
      n_err++;
      $display("FAIL ill_first_ack got=%b exp=1", p1_ack);
    end
    step();
    drive_move(1'b1, 2'd2, 2'd2);
    n_cmp++;
    if ({reject, p2_ack, turn, board_x, board_o} !== {1'b1, 1'b0, 1'b1, 9'h010, 9'h000}) begin
      n_err++;
      $display("FAIL ill_occupied rej=%b ack=%b turn=%b x=%h o=%h exp rej=1 ack=0 turn=1 x=010 o=000",
               reject, p2_ack, turn, board_x, board_o);
    end
    step();
    n_cmp++;
    if ({reject, turn} !== 2'b01) begin
      n_err++;
      $display("FAIL ill_reject_pulse rej=%b turn=%b exp rej=0 turn=1", reject, turn);
    end
    drive_move(1'b1, 2'd0, 2'd3);
    n_cmp++;
    if ({reject, p2_ack, board_o} !== {1'b1, 1'b0, 9'h000}) begin
      n_err++;
      $display("FAIL ill_zero_coord rej=%b ack=%b o=%h exp rej=1 ack=0 o=000", reject, p2_ack, board_o);
    end
    // Wrong player's request is ignored.
    p1_valid = 1'b1; p1_row = 2'd1; p1_col = 2'd1;
    step(); step(); step();
    p1_valid = 1'b0;
    n_cmp++;
    if ({p1_ack, p2_ack, reject, turn, board_x} !== {3'b000, 1'b1, 9'h010}) begin
      n_err++;
      $display("FAIL ill_wrong_player acks=%b%b rej=%b turn=%b x=%h exp none turn=1 x=010",
               p1_ack, p2_ack, reject, turn, board_x);
    end
    drive_move(1'b1, 2'd1, 2'd1);
    n_cmp++;
    if ({p2_ack, board_o} !== {1'b1, 9'h001}) begin
      n_err++;
      $display("FAIL ill_then_legal ack=%b o=%h exp ack=1 o=001", p2_ack, board_o);
    end
    step();
  endtask

  task automatic test_restart();
    do_start();
    drive_move(1'b0, 2'd1, 2'd1); step();
    drive_move(1'b1, 2'd1, 2'd2); step();
    drive_move(1'b0, 2'd1, 2'd3); step();
    drive_move(1'b1, 2'd2, 2'd2); step();
    n_cmp++;
    if ({board_x, board_o, turn} !== {9'h005, 9'h012, 1'b0}) begin
      n_err++;
      $display("FAIL restart_pre x=%h o=%h turn=%b exp x=005 o=012 turn=0", board_x, board_o, turn);
    end
    start = 1'b1;
    p1_valid = 1'b1; p1_row = 2'd3; p1_col = 2'd3;
    step();
    start = 1'b0;
    p1_valid = 1'b0;
    n_cmp++;
    if ({board_x, board_o, turn, p1_ack, busy, winner} !== {18'd0, 1'b0, 1'b0, 1'b1, 2'b00}) begin
      n_err++;
      $display("FAIL restart_clear x=%h o=%h turn=%b ack=%b busy=%b win=%b exp boards=0 turn=0 ack=0 busy=1 win=00",
               board_x, board_o, turn, p1_ack, busy, winner);
    end
  endtask

  task automatic test_reset_mid_check();
    logic [26:0] obs;
    do_start();
    drive_move(1'b0, 2'd2, 2'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    obs = {board_x, board_o, turn, busy, game_over, winner, p1_ack, p2_ack, reject, timeout};
    n_cmp++;
    if (obs !== 27'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs got=%h exp=0", obs);
    end
    p1_valid = 1'b1; p1_row = 2'd2; p1_col = 2'd2;
    step(); step(); step();
    p1_valid = 1'b0;
    n_cmp++;
    if ({board_x, p1_ack, busy} !== {9'h000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rstmid_idle x=%h ack=%b busy=%b exp x=000 ack=0 busy=0", board_x, p1_ack, busy);
    end
    do_start();
    drive_move(1'b0, 2'd3, 2'd1);
    n_cmp++;
    if ({p1_ack, board_x} !== {1'b1, 9'h040}) begin
      n_err++;
      $display("FAIL rstmid_resume ack=%b x=%h exp ack=1 x=040", p1_ack, board_x);
    end
    step();
  endtask

`ifdef TTT_MOVE_TIMEOUT_EN
  task automatic test_timeout();
    do_start();
    for (int i = 0; i < 7; i++) step();
    n_cmp++;
    if ({timeout, turn} !== 2'b00) begin
      n_err++;
      $display("FAIL tmo_early tmo=%b turn=%b exp tmo=0 turn=0", timeout, turn);
    end
    step();
    n_cmp++;
    if ({timeout, turn, board_x, board_o} !== {1'b1, 1'b1, 18'd0}) begin
      n_err++;
      $display("FAIL tmo_expire tmo=%b turn=%b x=%h o=%h exp tmo=1 turn=1 boards=0",
               timeout, turn, board_x, board_o);
    end
    for (int i = 0; i < 7; i++) step();
    drive_move(1'b1, 2'd2, 2'd2);
    n_cmp++;
    if ({p2_ack, timeout, board_o} !== {1'b1, 1'b0, 9'h010}) begin
      n_err++;
      $display("FAIL tmo_move_wins ack=%b tmo=%b o=%h exp ack=1 tmo=0 o=010", p2_ack, timeout, board_o);
    end
    step();
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0;
    p1_valid = 1'b0; p1_row = 2'd0; p1_col = 2'd0;
    p2_valid = 1'b0; p2_row = 2'd0; p2_col = 2'd0;
    test_reset();
    test_x_wins();
    test_draw();
    test_illegal();
    test_restart();
    test_reset_mid_check();
`ifdef TTT_MOVE_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ttt_turn_controller.md
# ttt_turn_controller

Sequencing controller for the tic-tac-toe datapath. Arbitrates moves from two players, decodes each row/column pair to a one-hot cell, and rejects illegal moves. Commits legal moves into the 9-cell board registers, detects win or draw, and alternates turns. Sits between the player input logic and the board display/status logic, and owns the board state.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1000: cycles allowed per turn before forfeit; used only with `TTT_MOVE_TIMEOUT_EN`, minimum 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin or restart a game.
- `p1_valid`  in  1  player 1 (X) move request.
- `p1_row`, `p1_col`  in  2 each  player 1 coordinates.
- `p2_valid`  in  1  player 2 (O) move request.
- `p2_row`, `p2_col`  in  2 each  player 2 coordinates.
- `p1_ack`, `p2_ack`  out  1 each  one-cycle pulse: move committed.
- `reject`  out  1  one-cycle pulse: current player's move illegal.
- `timeout`  out  1  one-cycle pulse: turn forfeited.
- `board_x`, `board_o`  out  9 each  occupancy, bit index `(row-1)*3+(col-1)`.
- `turn`  out  1  0 = X to move, 1 = O to move.
- `busy`  out  1  game in progress (states TURN/CHECK).
- `game_over`  out  1  game finished.
- `winner`  out  2  00 none, 01 X, 10 O, 11 draw.

## Operation
- Coordinate encoding:
  - Row/col values 1..3 are valid.
  - Value 0 on either coordinate is illegal.
  - Cell = `(row-1)*3 + (col-1)`.
- FSM states: IDLE, TURN, CHECK, DONE. Reset enters IDLE.
- `start` (any state, highest priority):
  - Clears both boards, `winner`, `game_over`, and `turn`.
  - Next state TURN.
  - Any move presented in the same cycle is ignored.
- IDLE: all move inputs ignored.
- TURN:
  - Only the current player's `valid` is sampled. The other player's `valid` is ignored, with no ack and no reject.
  - Legal move (both coordinates nonzero, cell empty in `board_x|board_o`):
    - The current player's board bit is set.
    - The matching ack pulses.
    - Next state CHECK.
  - Illegal move: `reject` pulses and the FSM stays in TURN.
  - A requester holds `valid` until it sees ack or reject.
- CHECK evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) on the mover's board:
  - Line complete: `winner` = mover, next state DONE.
  - Else all 9 cells occupied: `winner` = 11, next state DONE.
  - Else `turn` toggles, next state TURN.
  - All `valid` inputs are ignored in CHECK.
- DONE:
  - `game_over` = 1; board is frozen.
  - Moves are ignored; only `start` or reset leaves DONE.
- Reset values:
  - FSM in IDLE.
  - `board_x` = `board_o` = 0, `turn` = 0, `winner` = 00.
  - `busy`, `game_over`, `p1_ack`, `p2_ack`, `reject`, `timeout` all 0.
- Reset mid-game aborts the game. No partial commit is visible after reset.

## Timing
- Move sampled at edge N (FSM in TURN):
  - Board bit and ack/reject are visible after edge N (registered outputs).
  - After edge N+1, `turn` has toggled, or `winner`/`game_over` are set.
- Move-to-next-turn latency: 2 cycles. Earliest acceptance of the next player's move is at edge N+2.
- `start` sampled at edge N: boards are cleared and `busy` = 1 after edge N.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `TTT_MOVE_TIMEOUT_EN`.
- Defined:
  - A turn counter clears on each entry to TURN.
  - If no legal move is committed within `TIMEOUT_CYCLES` cycles in TURN, `timeout` pulses for one cycle and `turn` toggles with no board change. The FSM stays in TURN and the counter restarts.
  - A legal move arriving in the expiry cycle wins over the timeout.
  - `reject` does not clear the counter.
- Undefined:
  - No counter is built; `timeout` is tied to 0.
  - A turn waits indefinitely.

## Test plan
- X wins top row: after `start`, play X(1,1), O(2,1), X(1,2), O(2,2), X(1,3). Required: each ack pulses, `board_x`=0x007, `board_o`=0x018, `winner`=01, `game_over`=1.
- Draw: play X(1,1) O(1,2) X(1,3) O(2,2) X(2,1) O(2,3) X(3,2) O(3,1) X(3,3). Required: `board_x`=0x18D, `board_o`=0x072, `winner`=11.
- Illegal moves:
  - X(2,2) accepted; then O(2,2) → `reject` pulse, `turn` stays 1, board unchanged.
  - O(0,3) → `reject`.
  - `p1_valid` asserted during O's turn → no response.
- Restart: mid-game with 4 cells filled, assert `start` together with `p1_valid`. Required: boards 0, `turn` 0, no ack.
- Reset mid-CHECK: drive `rst_n`=0 for one cycle. Required: all outputs at reset values, FSM in IDLE, moves ignored until `start`.
- With `TTT_MOVE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8: X idle for 8 cycles in TURN. Required: `timeout` pulse, `turn`=1, boards unchanged. A legal move landing on the expiry cycle → ack and no `timeout`.
